opb_register_bank: RTL
======================

Name: opb_register_bank

Overview:
- Parametrised OPB slave exposing C_NUM_REGS 32-bit software registers between the PowerPC and the fabric user logic.
- Next-generation replacement for the single-register PPC-to-fabric block:
  - multiple registers per bus window
  - byte-enable writes and readback
  - per-register read-only (fabric-to-PPC) mapping
  - per-register write strobes
  - optional atomic shadow/commit update so multi-word settings change on the same cycle.
- Sits on the OPB next to the other register cores; clocked entirely by OPB_Clk.

Parameters:
- C_BASEADDR, 32'h010B0000, window base; must be aligned to window size.
- C_HIGHADDR, 32'h010B00FF, window top; (C_HIGHADDR-C_BASEADDR+1) is a power of two, at least 4*(C_NUM_REGS+1).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- C_NUM_REGS, 8, register count, 1..32.
- C_RO_MASK, 0, bit i=1: register i is read-only and returns user_data_in word i.
- C_ATOMIC, 0, 1 enables shadow registers plus a commit register.
- C_RESET_VAL, 32'h00000000, reset value of every RW register and its shadow.

Ports:
- OPB_Clk  in  1  bus and user clock.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7], the MSB byte.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_out  out  [32*C_NUM_REGS-1:0]  word i at bits [32i+31:32i]; OPB_DBus[k] maps to user bit 31-k.
- user_data_in  in  [32*C_NUM_REGS-1:0]  readback source for RO registers.
- user_wr_stb  out  [C_NUM_REGS-1:0]  one-cycle update pulse per register.
- user_commit_stb  out  1  one-cycle pulse on commit; tied 0 when C_ATOMIC=0.

Behaviour:
Reset:
- Applying OPB_Rst_n=0 immediately forces:
  - state IDLE
  - Sl_xferAck=0 and Sl_DBus=0
  - strobes 0
  - outputs and shadows = C_RESET_VAL (RO output words are 0)
  - dirty mask 0.
- A transfer in flight is dropped without ack; the master times out. No partial write survives.

Decode:
- hit = OPB_select & ((OPB_ABus & ~(C_HIGHADDR-C_BASEADDR)) == C_BASEADDR).
- Word index = offset[..:2]. Index C_NUM_REGS is the commit register. Higher indices are unmapped: reads return 0, writes are ignored, both are acked.

FSM (IDLE, ACK):
- IDLE, hit: go to ACK. On that edge:
  - the write is applied, or read data is registered
  - user_data_in is sampled for RO reads.
- ACK: drive Sl_xferAck=1 and valid Sl_DBus for exactly one cycle, then return to IDLE.
- Latency is 1 wait cycle; ack is in cycle T+1 for select first seen in cycle T.
- In IDLE, select still high after an ack is treated as a new transfer, so back-to-back transfers take 2 cycles each.

Writes:
- Byte-merged under OPB_BE. BE=0000 is acked with no change and no strobe.
- A write to an RO register is acked and ignored.
- C_ATOMIC=0:
  - register i updates at the edge ending T
  - user_data_out and user_wr_stb[i]=1 are seen in T+1.
- C_ATOMIC=1:
  - register writes go to shadow i and set dirty[i] if any enabled byte differs; outputs and strobes are unchanged.
  - any write to the commit register (any non-zero BE) copies all shadows to outputs at the edge ending T.
  - in T+1: user_commit_stb=1, user_wr_stb = the old dirty mask, dirty cleared.

Reads:
- RW register: returns shadow (atomic) or output value.
- RO register: returns the sampled user_data_in.
- Commit register: returns the dirty mask zero-extended, bit 0 in LSB; returns 0 when C_ATOMIC=0.
- Reads have no side effects.

Decomposition:
- Package opb_regbank_pkg holds:
  - FSM state encoding
  - word-index width function clog2(C_NUM_REGS+1)
  - OPB-to-user bit-reversal function
  - byte-merge function.
- One sub-module, opb_regbank_slot, is instantiated per register. It holds shadow, output and dirty bit, with inputs wr_en, be, wdata and commit.
- Top level holds decode, the FSM and the read mux.

Test Plan:
1. Reset, then read reg 3 at 0x010B000C. Required: ack in cycle T+1, Sl_DBus=0x00000000, Sl_DBus=0 in all other cycles.
2. C_ATOMIC=0: write 0xDEADBEEF with BE=1111 to reg 2, then BE=0100 write 0x00AA0000. Required: user word 2 = 0xDEAABEEF, user_wr_stb[2] pulses once per write, both in T+1.
3. C_RO_MASK=0x10, user_data_in word 4 = 0x12345678: write 0xFFFFFFFF to reg 4, then read it. Required: no strobe, read returns 0x12345678.
4. C_ATOMIC=1: write regs 0 and 1, then check outputs. Required: outputs unchanged, commit read = 0x3. Then write the commit register. Required: both words change on the same cycle, user_commit_stb=1, user_wr_stb=0b11, commit read = 0.
5. Read at unmapped offset 0x80 and write to address 0x010B0100. Required: the first is acked with data 0; the second gets no ack.
6. Assert OPB_Rst_n=0 during the ACK cycle of a write. Required: ack drops at once and all outputs return to C_RESET_VAL.

Source files
------------

// File: rtl/opb_regbank_pkg.sv
// rtl/opb_regbank_pkg.sv - shared types and helpers for the OPB register bank
package opb_regbank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  function automatic int idx_width(input int num_regs);
    return (num_regs < 1) ? 1 : $clog2(num_regs + 1);
  endfunction

  // OPB numbers bits from the MSB; user words number from the LSB
  function automatic logic [31:0] opb_to_user(input logic [0:31] d);
    logic [31:0] u;
    for (int k = 0; k < 32; k++) u[31-k] = d[k];
    return u;
  endfunction

  function automatic logic [0:31] user_to_opb(input logic [31:0] u);
    logic [0:31] d;
    for (int k = 0; k < 32; k++) d[k] = u[31-k];
    return d;
  endfunction

  function automatic logic [3:0] be_to_user(input logic [0:3] be);
    logic [3:0] u;
    for (int k = 0; k < 4; k++) u[3-k] = be[k];
    return u;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_regbank_slot.sv
// rtl/opb_regbank_slot.sv - one read/write register with optional shadow and dirty tracking
module opb_regbank_slot
  import opb_regbank_pkg::*;
#(
  parameter bit          ATOMIC    = 1'b0,
  parameter logic [31:0] RESET_VAL = 32'h0
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        commit,
  output logic [31:0] data_out,
  output logic [31:0] rd_val,
  output logic        dirty,
  output logic        wr_stb
);

  logic [31:0] out_q, out_d;
  logic [31:0] shadow_q, shadow_d;
  logic        dirty_q, dirty_d;
  logic        stb_q, stb_d;
  logic [31:0] merged;

  always_comb begin
    out_d    = out_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    stb_d    = 1'b0;
    merged   = 32'h0;
    if (ATOMIC) begin
      merged = byte_merge(shadow_q, wdata, be);
      if (wr_en) begin
        shadow_d = merged;
        if (merged != shadow_q) dirty_d = 1'b1;
      end
      // Strobe reports which words actually changed since the last commit
      if (commit) begin
        out_d   = shadow_q;
        stb_d   = dirty_q;
        dirty_d = 1'b0;
      end
    end else begin
      merged = byte_merge(out_q, wdata, be);
      if (wr_en) begin
        out_d = merged;
        stb_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= RESET_VAL;
      shadow_q <= RESET_VAL;
      dirty_q  <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      stb_q    <= stb_d;
    end
  end

  assign data_out = out_q;
  assign rd_val   = ATOMIC ? shadow_q : out_q;
  assign dirty    = dirty_q;
  assign wr_stb   = stb_q;

endmodule

// File: rtl/opb_register_bank.sv
// rtl/opb_register_bank.sv - OPB slave exposing a bank of 32-bit software registers
module opb_register_bank
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010B0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [31:0] C_RO_MASK    = 32'h0,
  parameter int          C_ATOMIC     = 0,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
)(
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  input  logic [32*C_NUM_REGS-1:0]  user_data_in,
  output logic [C_NUM_REGS-1:0]     user_wr_stb,
  output logic                      user_commit_stb
);

  localparam int          IW       = idx_width(C_NUM_REGS);
  localparam logic [31:0] WIN_MASK = C_HIGHADDR - C_BASEADDR;
  localparam bit          ATOMIC   = (C_ATOMIC != 0);

  logic [31:0] addr, offset, word_idx;
  logic [IW-1:0] reg_idx;
  logic hit, is_reg, is_commit, be_any;
  logic [3:0]  be_u;
  logic [31:0] wdata_u, rd_mux;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        commit_q, commit_d;
  logic [C_NUM_REGS-1:0] wr_en_vec, dirty_vec, stb_vec;
  logic [31:0] slot_rd [C_NUM_REGS];

  assign addr      = 32'(OPB_ABus);
  assign hit       = OPB_select && ((addr & ~WIN_MASK) == C_BASEADDR);
  assign offset    = addr & WIN_MASK;
  assign word_idx  = offset >> 2;
  assign reg_idx   = word_idx[IW-1:0];
  assign is_reg    = word_idx < 32'(C_NUM_REGS);
  assign is_commit = word_idx == 32'(C_NUM_REGS);
  assign be_u      = be_to_user(OPB_BE);
  assign be_any    = be_u != 4'b0000;
  assign wdata_u   = opb_to_user(OPB_DBus);

  // RO words return live fabric data; unmapped offsets read as zero
  always_comb begin
    rd_mux = 32'h0;
    if (is_reg) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (reg_idx == IW'(i)) rd_mux = C_RO_MASK[i] ? user_data_in[32*i +: 32] : slot_rd[i];
      end
    end else if (is_commit && ATOMIC) begin
      rd_mux = 32'(dirty_vec);
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    rdata_d   = 32'h0;
    commit_d  = 1'b0;
    wr_en_vec = '0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (OPB_RNW) begin
            rdata_d = rd_mux;
          end else if (be_any) begin
            if (is_reg) begin
              for (int i = 0; i < C_NUM_REGS; i++) begin
                if (reg_idx == IW'(i)) wr_en_vec[i] = ~C_RO_MASK[i];
              end
            end else if (is_commit && ATOMIC) begin
              commit_d = 1'b1;
            end
          end
        end
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      rdata_q  <= 32'h0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      commit_q <= commit_d;
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_slot
    if (C_RO_MASK[g]) begin : g_ro
      assign user_data_out[32*g +: 32] = 32'h0;
      assign slot_rd[g]                = 32'h0;
      assign dirty_vec[g]              = 1'b0;
      assign stb_vec[g]                = 1'b0;
    end else begin : g_rw
      opb_regbank_slot #(
        .ATOMIC    (ATOMIC),
        .RESET_VAL (C_RESET_VAL)
      ) u_slot (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .wr_en    (wr_en_vec[g]),
        .be       (be_u),
        .wdata    (wdata_u),
        .commit   (commit_d),
        .data_out (user_data_out[32*g +: 32]),
        .rd_val   (slot_rd[g]),
        .dirty    (dirty_vec[g]),
        .wr_stb   (stb_vec[g])
      );
    end
  end

  assign Sl_DBus         = user_to_opb(rdata_q);
  assign Sl_xferAck      = ack_q;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_wr_stb     = stb_vec;
  assign user_commit_stb = commit_q;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, wr_en_vec, user_data_in};

endmodule
